alu_issue_ctrl: RTL and testbench

//  Initiator for the registered 32-bit ALU: accepts compact register-register instructions on a

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_32.sv | 47 ++++
 rtl/alu_ctrl_regfile.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode legality helper for the
// ALU issue controller and its companion ALU model.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_MUL    = 4'd2;
  localparam logic [3:0] ALU_SRL    = 4'd3;
  localparam logic [3:0] ALU_SLL    = 4'd4;
  localparam logic [3:0] ALU_AND    = 4'd5;
  localparam logic [3:0] ALU_OR     = 4'd6;
  localparam logic [3:0] ALU_XOR    = 4'd7;
  localparam logic [3:0] ALU_NOT    = 4'd8;
  localparam logic [3:0] ALU_OP_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_e;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_32.sv
// Registered 32-bit ALU: result and carry appear one clock after operands are
// sampled; carry only updates on ADD and is stale otherwise.
module alu_32
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [3:0]  select,
  output logic [31:0] y_out,
  output logic        carry_bit
);

  logic [32:0] sum;
  logic [31:0] y_d;

  assign sum = {1'b0, a_in} + {1'b0, b_in};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    y_d = '0;
    case (select)
      ALU_ADD: y_d = sum[31:0];
      ALU_SUB: y_d = a_in - b_in;
      ALU_MUL: y_d = a_in * b_in;
      ALU_SRL: y_d = a_in >> b_in[4:0];
      ALU_SLL: y_d = a_in << b_in[4:0];
      ALU_AND: y_d = a_in & b_in;
      ALU_OR:  y_d = a_in | b_in;
      ALU_XOR: y_d = a_in ^ b_in;
      ALU_NOT: y_d = ~a_in;
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_out     <= '0;
      carry_bit <= 1'b0;
    end else begin
      y_out <= y_d;
      if (select == ALU_ADD) carry_bit <= sum[32];
    end
  end

endmodule

// File: rtl/alu_ctrl_regfile.sv
// NREGS x DW register file: two asynchronous read ports, one write path where
// ALU writeback takes priority over a direct load to the same entry.
module alu_ctrl_regfile #(
  parameter  int DW    = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  logic [DW-1:0] mem_q [NREGS];

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

  // NOTE: the array is cleared by reset on purpose (all entries read 0 after reset), so it maps to flops, not RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      if (ld_en) mem_q[ld_addr] <= ld_data;
      // Later assignment wins, giving writeback priority on an address clash.
      if (wb_en) mem_q[wb_addr] <= wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue initiator for the registered ALU: IDLE -> ISSUE -> CAPTURE.
// Optional sticky-carry flag enabled by defining ALU_CTRL_STICKY_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS),
  localparam int IW    = 4 + 3 * AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_valid,
  output logic          ins_ready,
  input  logic [IW-1:0] ins_word,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_carry,
`ifdef ALU_CTRL_STICKY_EN
  input  logic          sticky_clr,
  output logic          sticky_c,
`endif
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [AW-1:0] res_rd,
  output logic          res_carry,
  output logic          res_err
);

  state_e        state_q, state_d;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [3:0]    alu_sel_q;
  logic          res_valid_q, res_carry_q, res_err_q;
  logic [DW-1:0] res_data_q;
  logic [AW-1:0] res_rd_q;

  logic [3:0]    ins_op;
  logic [AW-1:0] ins_rd, ins_rs1, ins_rs2;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          accept, capture, op_bad, wb_en;

  assign {ins_op, ins_rd, ins_rs1, ins_rs2} = ins_word;
  assign ins_ready = (state_q == IDLE);
  assign accept    = ins_valid & ins_ready;
  assign capture   = (state_q == CAPTURE);
  assign op_bad    = op_illegal(op_q);
  assign wb_en     = capture & ~op_bad;

  alu_ctrl_regfile #(.DW(DW), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ins_rs1),
    .rb_addr (ins_rs2),
    .ra_data (rs1_data),
    .rb_data (rs2_data),
    .wb_en   (wb_en),
    .wb_addr (rd_q),
    .wb_data (alu_y),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (accept) begin
        op_q      <= ins_op;
        rd_q      <= ins_rd;
        alu_a_q   <= rs1_data;
        alu_b_q   <= rs2_data;
        alu_sel_q <= ins_op;
      end
      if (capture) begin
        res_valid_q <= 1'b1;
        res_rd_q    <= rd_q;
        res_err_q   <= op_bad;
        res_data_q  <= op_bad ? '0 : alu_y;
        // ALU carry is only meaningful for ADD; it is stale for every other op.
        res_carry_q <= (op_q == ALU_ADD) ? alu_carry : 1'b0;
      end
    end
  end

`ifdef ALU_CTRL_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          sticky_q <= 1'b0;
    else if (capture && op_q == ALU_ADD && alu_carry) sticky_q <= 1'b1;
    else if (sticky_clr)                              sticky_q <= 1'b0;
  end

  assign sticky_c = sticky_q;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl driving an alu_32 instance; directed
// vectors with hand-computed results, checked by an independent monitor.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [15:0] ins_word = '0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_sel;
  logic        alu_carry;
  logic        res_valid, res_carry, res_err;
  logic [31:0] res_data;
  logic [3:0]  res_rd;
`ifdef ALU_CTRL_STICKY_EN
  logic        sticky_clr = 1'b0;
  logic        sticky_c;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [3:0]  rd;
    logic        carry;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  alu_issue_ctrl #(.DW(32), .NREGS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_word  (ins_word),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .alu_carry (alu_carry),
`ifdef ALU_CTRL_STICKY_EN
    .sticky_clr(sticky_clr),
    .sticky_c  (sticky_c),
`endif
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .res_carry (res_carry),
    .res_err   (res_err)
  );

  alu_32 u_alu (
    .clk       (clk),
    .rst       (rst),
    .a_in      (alu_a),
    .b_in      (alu_b),
    .select    (alu_sel),
    .y_out     (alu_y),
    .carry_bit (alu_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per result pulse, including the 3-cycle latency.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_data"},    res_data,       e.data);
        check({e.name, "_rd"},      {28'd0, res_rd}, {28'd0, e.rd});
        check({e.name, "_carry"},   {31'd0, res_carry}, {31'd0, e.carry});
        check({e.name, "_err"},     {31'd0, res_err},   {31'd0, e.err});
        check({e.name, "_latency"}, cyc, e.acc_cyc + 3);
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic load(input logic [3:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [31:0] data,
                       input logic carry, input logic err, input bit push, output int waits);
    waits = 0;
    while (!ins_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!ins_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    ins_valid = 1'b1;
    ins_word  = {op, rd, rs1, rs2};
    if (push) sb_q.push_back('{name, data, rd, carry, err, cyc});
    @(negedge clk);
    ins_valid = 1'b0;
    ld_en     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check({name, "_drain_timeout"}, sb_q.size(), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ins_ready"}, {31'd0, ins_ready}, 32'd1);
    check({name, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({name, "_res_data"},  res_data, 32'd0);
    check({name, "_res_rd"},    {28'd0, res_rd}, 32'd0);
    check({name, "_res_carry"}, {31'd0, res_carry}, 32'd0);
    check({name, "_res_err"},   {31'd0, res_err}, 32'd0);
    check({name, "_alu_a"},     alu_a, 32'd0);
    check({name, "_alu_b"},     alu_b, 32'd0);
    check({name, "_alu_sel"},   {28'd0, alu_sel}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_release");

    // 1: ADD with carry-out, result wraps to 0 and is written back.
    load(4'd1, 32'hFFFF_FFFF);
    load(4'd2, 32'h0000_0001);
    load(4'd3, 32'h0000_0055);
    issue("add_carry", ALU_ADD, 4'd3, 4'd1, 4'd2, 32'h0, 1'b1, 1'b0, 1, w);
    issue("rd_r3", ALU_OR, 4'd8, 4'd3, 4'd3, 32'h0, 1'b0, 1'b0, 1, w);

    // 2: back-to-back SLL then SUB; second accept waits exactly 2 cycles.
    load(4'd4, 32'h0000_0010);
    load(4'd5, 32'h0000_0004);
    issue("sll", ALU_SLL, 4'd6, 4'd4, 4'd5, 32'h0000_0100, 1'b0, 1'b0, 1, w);
    issue("sub", ALU_SUB, 4'd7, 4'd4, 4'd5, 32'h0000_000C, 1'b0, 1'b0, 1, w);
    check("b2b_ready_gap", w, 32'd2);

    // Remaining opcodes and writeback of r6/r7.
    issue("mul",     ALU_MUL, 4'd8, 4'd4, 4'd5, 32'h0000_0040, 1'b0, 1'b0, 1, w);
    issue("mul_wrap",ALU_MUL, 4'd8, 4'd1, 4'd1, 32'h0000_0001, 1'b0, 1'b0, 1, w);
    issue("srl",     ALU_SRL, 4'd8, 4'd4, 4'd5, 32'h0000_0001, 1'b0, 1'b0, 1, w);
    issue("and",     ALU_AND, 4'd8, 4'd4, 4'd5, 32'h0000_0000, 1'b0, 1'b0, 1, w);
    issue("or",      ALU_OR,  4'd8, 4'd4, 4'd5, 32'h0000_0014, 1'b0, 1'b0, 1, w);
    issue("xor",     ALU_XOR, 4'd8, 4'd4, 4'd4, 32'h0000_0000, 1'b0, 1'b0, 1, w);
    issue("not",     ALU_NOT, 4'd8, 4'd4, 4'd0, 32'hFFFF_FFEF, 1'b0, 1'b0, 1, w);
    issue("rd_r6r7", ALU_OR,  4'd9, 4'd6, 4'd7, 32'h0000_010C, 1'b0, 1'b0, 1, w);

    // 3: illegal opcodes report an error, drive alu_sel and leave rd alone.
    wait_done("pre_illegal");
    issue("ill_c", 4'hC, 4'd2, 4'd1, 4'd1, 32'h0, 1'b0, 1'b1, 1, w);
    check("ill_alu_sel", {28'd0, alu_sel}, 32'h0000_000C);
    check("ill_alu_a",   alu_a, 32'hFFFF_FFFF);
    issue("ill_9", 4'h9, 4'd2, 4'd1, 4'd1, 32'h0, 1'b0, 1'b1, 1, w);
    issue("rd_r2", ALU_OR, 4'd8, 4'd2, 4'd2, 32'h0000_0001, 1'b0, 1'b0, 1, w);

    // 4: load on the writeback edge to the same register loses; to another register both land.
    issue("wb_vs_ld", ALU_ADD, 4'd3, 4'd4, 4'd5, 32'h0000_0014, 1'b0, 1'b0, 1, w);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 4'd3; ld_data = 32'hAAAA_AAAA;
    @(negedge clk);
    ld_en = 1'b0;
    issue("rd_r3_wb", ALU_OR, 4'd8, 4'd3, 4'd3, 32'h0000_0014, 1'b0, 1'b0, 1, w);
    issue("wb_and_ld", ALU_ADD, 4'd10, 4'd4, 4'd5, 32'h0000_0014, 1'b0, 1'b0, 1, w);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 4'd11; ld_data = 32'h0000_0077;
    @(negedge clk);
    ld_en = 1'b0;
    issue("rd_r10r11", ALU_XOR, 4'd8, 4'd10, 4'd11, 32'h0000_0063, 1'b0, 1'b0, 1, w);

    // Load on the accept edge does not disturb that instruction's operands.
    wait_done("pre_acc_ld");
    ld_en = 1'b1; ld_addr = 4'd4; ld_data = 32'h0000_0999;
    issue("acc_ld", ALU_ADD, 4'd12, 4'd4, 4'd5, 32'h0000_0014, 1'b0, 1'b0, 1, w);
    check("acc_ld_no_wait", w, 32'd0);
    issue("rd_r4", ALU_OR, 4'd8, 4'd4, 4'd4, 32'h0000_0999, 1'b0, 1'b0, 1, w);

    // 5: reset during ISSUE drops the instruction and clears the register file.
    wait_done("pre_reset");
    issue("and_dropped", ALU_AND, 4'd9, 4'd4, 4'd5, 32'h0, 1'b0, 1'b0, 0, w);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_no_result", {31'd0, res_valid}, 32'd0);
    issue("add_r0", ALU_ADD, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, 1, w);
    issue("rf_clr_a", ALU_OR, 4'd8, 4'd1, 4'd6, 32'h0, 1'b0, 1'b0, 1, w);
    issue("rf_clr_b", ALU_OR, 4'd8, 4'd4, 4'd9, 32'h0, 1'b0, 1'b0, 1, w);
    wait_done("post_reset");

`ifdef ALU_CTRL_STICKY_EN
    // 6: sticky carry sets on a carrying ADD, survives a non-carrying ADD, clears on request.
    check("sticky_init", {31'd0, sticky_c}, 32'd0);
    load(4'd1, 32'hFFFF_FFFF);
    load(4'd2, 32'h0000_0001);
    issue("st_add_c", ALU_ADD, 4'd3, 4'd1, 4'd2, 32'h0, 1'b1, 1'b0, 1, w);
    wait_done("st1");
    check("sticky_set", {31'd0, sticky_c}, 32'd1);
    issue("st_add_nc", ALU_ADD, 4'd3, 4'd2, 4'd2, 32'h2, 1'b0, 1'b0, 1, w);
    wait_done("st2");
    check("sticky_keep", {31'd0, sticky_c}, 32'd1);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("sticky_clr", {31'd0, sticky_c}, 32'd0);
`endif

    wait_done("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
